// File: rtl/l1_d_pkg.sv
// Shared definitions for the L1 data-cache controller: geometry, FSM states, address slicing.
// Latency: n/a (types, constants and pure functions only).
// Backpressure: n/a.
package l1_d_pkg;

    localparam int ADDR_BITS = 32;
    localparam int INDEX_W   = 6;
    localparam int OFFSET_W  = 6;
    localparam int TAG_W     = 20;
    localparam int LINE_W    = 512;
    localparam int NUM_SETS  = 64;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WB_REQ,
        ST_WB_WAIT,
        ST_AL_REQ,
        ST_AL_WAIT,
        ST_REFILL
    } state_t;

    function automatic logic [TAG_W-1:0] addr_tag(input logic [ADDR_BITS-1:0] a);
        return a[ADDR_BITS-1 -: TAG_W];
    endfunction

    function automatic logic [INDEX_W-1:0] addr_index(input logic [ADDR_BITS-1:0] a);
        return a[OFFSET_W +: INDEX_W];
    endfunction

    function automatic logic [OFFSET_W-1:0] addr_offset(input logic [ADDR_BITS-1:0] a);
        return a[OFFSET_W-1:0];
    endfunction

    // Line-aligned address: byte offset forced to zero.
    function automatic logic [ADDR_BITS-1:0] line_addr(input logic [ADDR_BITS-1:0] a);
        return {a[ADDR_BITS-1:OFFSET_W], {OFFSET_W{1'b0}}};
    endfunction

endpackage

// File: rtl/l1_d_cache_controller_tag_array.sv
// Tag/valid/dirty storage for 64 direct-mapped sets, combinational read port.
// Latency: read 0 cycles; fill and dirty-mark take effect at the next rising edge.
// Backpressure: none, writes are always accepted.
// Ports: clk/rst (sync, active-high; clears valid/dirty only, tags keep contents),
//   rd_index_i -> rd_valid_o/rd_dirty_o/rd_tag_o, fill_* (install clean valid line),
//   mark_dirty_i/mark_index_i (store hit).
module l1_d_cache_controller_tag_array
    import l1_d_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic [INDEX_W-1:0] rd_index_i,
    output logic               rd_valid_o,
    output logic               rd_dirty_o,
    output logic [TAG_W-1:0]   rd_tag_o,
    input  logic               fill_i,
    input  logic [INDEX_W-1:0] fill_index_i,
    input  logic [TAG_W-1:0]   fill_tag_i,
    input  logic               mark_dirty_i,
    input  logic [INDEX_W-1:0] mark_index_i
);

    logic [NUM_SETS-1:0] valid_q;
    logic [NUM_SETS-1:0] dirty_q;
    logic [TAG_W-1:0]    tag_q [NUM_SETS];

    assign rd_valid_o = valid_q[rd_index_i];
    assign rd_dirty_o = dirty_q[rd_index_i];
    assign rd_tag_o   = tag_q[rd_index_i];

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= '0;
            dirty_q <= '0;
        end else begin
            if (fill_i) begin
                valid_q[fill_index_i] <= 1'b1;
                dirty_q[fill_index_i] <= 1'b0;
            end
            // Fill and dirty-mark never coincide: fill happens outside IDLE.
            if (mark_dirty_i) begin
                dirty_q[mark_index_i] <= 1'b1;
            end
        end
    end

    // Tags are meaningless while valid is clear, so they carry no reset.
    always_ff @(posedge clk) begin
        if (fill_i) begin
            tag_q[fill_index_i] <= fill_tag_i;
        end
    end

endmodule

// File: rtl/l1_d_cache_controller.sv
// Direct-mapped write-back/write-allocate L1 D-cache controller (tags + miss FSM + L2 handshake).
// Latency: hit 0 cycles; clean miss stalls 4 cycles, dirty miss 6, plus any L2 wait.
// Backpressure: stall_L1 holds the core; L2 request is held valid and stable until l2_req_ready.
// Ports: cpu_req_* in / stall_L1, index, offset, update_L1, refill_L1 out toward core and data array;
//   victim_data from the array; l2_req_* / l2_wdata out and l2_req_ready, l2_resp_valid in toward L2.
// Option: define L1_D_PERF_CNT_EN to add saturating hit_cnt / miss_cnt outputs.
module l1_d_cache_controller #(
    parameter int ADDR_W = 32,
    parameter int LINE_W = 512,
    parameter int TAG_W  = ADDR_W - 12
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cpu_req_valid,
    input  logic              cpu_req_we,
    input  logic [ADDR_W-1:0] cpu_req_addr,
    output logic              stall_L1,
    output logic [5:0]        index,
    output logic [5:0]        offset,
    output logic              update_L1,
    output logic              refill_L1,
    input  logic [LINE_W-1:0] victim_data,
    output logic              l2_req_valid,
    output logic              l2_req_we,
    output logic [ADDR_W-1:0] l2_req_addr,
    output logic [LINE_W-1:0] l2_wdata,
    input  logic              l2_req_ready,
    input  logic              l2_resp_valid
`ifdef L1_D_PERF_CNT_EN
    ,
    output logic [31:0]       hit_cnt,
    output logic [31:0]       miss_cnt
`endif
);

    import l1_d_pkg::*;

    state_t              state_q;
    logic                l2_req_valid_q;
    logic                l2_req_we_q;
    logic [ADDR_W-1:0]   l2_req_addr_q;
    logic [LINE_W-1:0]   l2_wdata_q;
    logic                refill_q;

    logic [INDEX_W-1:0]  req_index;
    logic [TAG_W-1:0]    req_tag;
    logic [ADDR_W-1:0]   al_addr_d;
    logic [ADDR_W-1:0]   wb_addr_d;
    logic                rd_valid;
    logic                rd_dirty;
    logic [TAG_W-1:0]    rd_tag;
    logic                in_idle;
    logic                hit;
    logic                miss;

    assign req_index = addr_index(cpu_req_addr);
    assign req_tag   = addr_tag(cpu_req_addr);
    assign al_addr_d = line_addr(cpu_req_addr);
    assign wb_addr_d = {rd_tag, req_index, {OFFSET_W{1'b0}}};

    assign in_idle = (state_q == ST_IDLE);
    assign hit     = cpu_req_valid && rd_valid && (rd_tag == req_tag);
    assign miss    = in_idle && cpu_req_valid && !hit;

    assign index     = req_index;
    assign offset    = addr_offset(cpu_req_addr);
    assign stall_L1  = !in_idle || miss;
    assign update_L1 = in_idle && hit && cpu_req_we;
    assign refill_L1 = refill_q;

    assign l2_req_valid = l2_req_valid_q;
    assign l2_req_we    = l2_req_we_q;
    assign l2_req_addr  = l2_req_addr_q;
    assign l2_wdata     = l2_wdata_q;

    l1_d_cache_controller_tag_array u_tags (
        .clk          (clk),
        .rst          (rst),
        .rd_index_i   (req_index),
        .rd_valid_o   (rd_valid),
        .rd_dirty_o   (rd_dirty),
        .rd_tag_o     (rd_tag),
        .fill_i       (state_q == ST_REFILL),
        .fill_index_i (req_index),
        .fill_tag_i   (req_tag),
        .mark_dirty_i (update_L1),
        .mark_index_i (req_index)
    );

    // The request is not latched: the core holds cpu_req_* stable while stalled,
    // so index/tag stay valid for the victim address and the refill write.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= ST_IDLE;
            l2_req_valid_q <= 1'b0;
            l2_req_we_q    <= 1'b0;
            l2_req_addr_q  <= '0;
            l2_wdata_q     <= '0;
            refill_q       <= 1'b0;
        end else begin
            refill_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (miss) begin
                        l2_req_valid_q <= 1'b1;
                        if (rd_valid && rd_dirty) begin
                            state_q       <= ST_WB_REQ;
                            l2_req_we_q   <= 1'b1;
                            l2_req_addr_q <= wb_addr_d;
                            l2_wdata_q    <= victim_data;
                        end else begin
                            state_q       <= ST_AL_REQ;
                            l2_req_we_q   <= 1'b0;
                            l2_req_addr_q <= al_addr_d;
                        end
                    end
                end
                ST_WB_REQ: begin
                    if (l2_req_ready) begin
                        state_q        <= ST_WB_WAIT;
                        l2_req_valid_q <= 1'b0;
                    end
                end
                ST_WB_WAIT: begin
                    if (l2_resp_valid) begin
                        state_q        <= ST_AL_REQ;
                        l2_req_valid_q <= 1'b1;
                        l2_req_we_q    <= 1'b0;
                        l2_req_addr_q  <= al_addr_d;
                    end
                end
                ST_AL_REQ: begin
                    if (l2_req_ready) begin
                        state_q        <= ST_AL_WAIT;
                        l2_req_valid_q <= 1'b0;
                    end
                end
                ST_AL_WAIT: begin
                    if (l2_resp_valid) begin
                        state_q  <= ST_REFILL;
                        refill_q <= 1'b1;
                    end
                end
                ST_REFILL: begin
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q        <= ST_IDLE;
                    l2_req_valid_q <= 1'b0;
                end
            endcase
        end
    end

`ifdef L1_D_PERF_CNT_EN
    logic [31:0] hit_cnt_q;
    logic [31:0] miss_cnt_q;
    logic        rehit_q;   // first IDLE cycle after a refill: the re-hit is not a new hit

    always_ff @(posedge clk) begin
        if (rst) begin
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
            rehit_q    <= 1'b0;
        end else begin
            rehit_q <= (state_q == ST_REFILL);
            if (in_idle && hit && !rehit_q && (hit_cnt_q != '1)) begin
                hit_cnt_q <= hit_cnt_q + 32'd1;
            end
            if (miss && (miss_cnt_q != '1)) begin
                miss_cnt_q <= miss_cnt_q + 32'd1;
            end
        end
    end

    assign hit_cnt  = hit_cnt_q;
    assign miss_cnt = miss_cnt_q;
`endif

endmodule

// File: tb/tb_l1_d_cache_controller.sv
// Directed self-checking bench for l1_d_cache_controller with a small L2 responder model.
// Latency: n/a (testbench).
// Backpressure: responder withholds l2_req_ready for bp_need valid cycles; resp one cycle after accept.
module tb_l1_d_cache_controller;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst;
    logic         cpu_req_valid;
    logic         cpu_req_we;
    logic [31:0]  cpu_req_addr;
    logic         stall_L1;
    logic [5:0]   index;
    logic [5:0]   offset;
    logic         update_L1;
    logic         refill_L1;
    logic [511:0] victim_data;
    logic         l2_req_valid;
    logic         l2_req_we;
    logic [31:0]  l2_req_addr;
    logic [511:0] l2_wdata;
    logic         l2_req_ready;
    logic         l2_resp_valid;
`ifdef L1_D_PERF_CNT_EN
    logic [31:0]  hit_cnt;
    logic [31:0]  miss_cnt;
`endif

    l1_d_cache_controller dut (
        .clk           (clk),
        .rst           (rst),
        .cpu_req_valid (cpu_req_valid),
        .cpu_req_we    (cpu_req_we),
        .cpu_req_addr  (cpu_req_addr),
        .stall_L1      (stall_L1),
        .index         (index),
        .offset        (offset),
        .update_L1     (update_L1),
        .refill_L1     (refill_L1),
        .victim_data   (victim_data),
        .l2_req_valid  (l2_req_valid),
        .l2_req_we     (l2_req_we),
        .l2_req_addr   (l2_req_addr),
        .l2_wdata      (l2_wdata),
        .l2_req_ready  (l2_req_ready),
        .l2_resp_valid (l2_resp_valid)
`ifdef L1_D_PERF_CNT_EN
        ,
        .hit_cnt       (hit_cnt),
        .miss_cnt      (miss_cnt)
`endif
    );

    int checks   = 0;
    int errors   = 0;
    int both_err = 0;
    int stab_err = 0;

    // L2 responder model
    int   bp_need = 0;
    int   vcnt    = 0;
    logic pend    = 1'b0;
    logic resp_en;
    logic resp_force;

    assign l2_req_ready  = (vcnt >= bp_need);
    assign l2_resp_valid = (pend && resp_en) || resp_force;

    always @(posedge clk) begin
        if (rst) begin
            vcnt <= 0;
            pend <= 1'b0;
        end else begin
            if (!l2_req_valid || l2_req_ready) vcnt <= 0;
            else                               vcnt <= vcnt + 1;
            if (l2_req_valid && l2_req_ready) pend <= 1'b1;
            else if (l2_resp_valid)           pend <= 1'b0;
        end
    end

    logic [31:0]  acc_addr  [4];
    logic         acc_we    [4];
    logic [511:0] acc_wdata [4];

    localparam logic [511:0] VIC = {8{64'h0123_4567_89AB_CDEF}};

    typedef struct {
        logic        v;
        logic        we;
        logic [31:0] addr;
        logic        stall;
        logic        upd;
        logic [5:0]  idx;
        logic [5:0]  off;
    } vec_t;
    vec_t tbl [9];

    task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic v, input logic we, input logic [31:0] a);
        @(posedge clk);
        #1;
        cpu_req_valid = v;
        cpu_req_we    = we;
        cpu_req_addr  = a;
    endtask

    // Watches a miss from its detect cycle (c0) until stall_L1 drops; ends on that negedge.
    task automatic observe(output int stall_cyc, output int nacc, output int refills, output int refill_at);
        logic         pv;
        logic [31:0]  pa;
        logic         pw;
        logic [511:0] pd;
        stall_cyc = 0; nacc = 0; refills = 0; refill_at = -1;
        pv = 1'b0; pa = '0; pw = 1'b0; pd = '0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (update_L1 && refill_L1) both_err++;
            if (pv && (!l2_req_valid || l2_req_addr !== pa || l2_req_we !== pw || l2_wdata !== pd))
                stab_err++;
            pv = l2_req_valid && !l2_req_ready;
            pa = l2_req_addr; pw = l2_req_we; pd = l2_wdata;
            if (l2_req_valid && l2_req_ready) begin
                if (nacc < 4) begin
                    acc_addr[nacc]  = l2_req_addr;
                    acc_we[nacc]    = l2_req_we;
                    acc_wdata[nacc] = l2_wdata;
                end
                nacc++;
            end
            if (refill_L1) begin
                refills++;
                refill_at = c;
            end
            if (!stall_L1) return;
            stall_cyc++;
        end
        checks++;
        errors++;
        $display("FAIL miss_timeout stall still high after %0d cycles, required low", 40);
    endtask

    int sc, na, rf, ra;

    initial begin
        tbl[0] = '{1'b0, 1'b0, 32'h0000_2040, 1'b0, 1'b0, 6'd1, 6'd0};
        tbl[1] = '{1'b0, 1'b1, 32'h0000_2044, 1'b0, 1'b0, 6'd1, 6'd4};
        tbl[2] = '{1'b1, 1'b0, 32'h0000_2040, 1'b0, 1'b0, 6'd1, 6'd0};
        tbl[3] = '{1'b1, 1'b1, 32'h0000_207F, 1'b0, 1'b1, 6'd1, 6'h3F};
        tbl[4] = '{1'b1, 1'b1, 32'h0000_3080, 1'b0, 1'b1, 6'd2, 6'd0};
        tbl[5] = '{1'b1, 1'b0, 32'h0000_30BC, 1'b0, 1'b0, 6'd2, 6'h3C};
        tbl[6] = '{1'b1, 1'b0, 32'h0000_1040, 1'b1, 1'b0, 6'd1, 6'd0};
        tbl[7] = '{1'b1, 1'b1, 32'h0000_20C0, 1'b1, 1'b0, 6'd3, 6'd0};
        tbl[8] = '{1'b1, 1'b0, 32'hFFFF_F040, 1'b1, 1'b0, 6'd1, 6'd0};

        rst = 1'b1; cpu_req_valid = 1'b0; cpu_req_we = 1'b0; cpu_req_addr = '0;
        victim_data = VIC; resp_en = 1'b1; resp_force = 1'b0; bp_need = 0;

        // Reset for two cycles
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_stall",    stall_L1,     0);
        check("rst_update",   update_L1,    0);
        check("rst_refill",   refill_L1,    0);
        check("rst_l2_valid", l2_req_valid, 0);
        check("rst_l2_we",    l2_req_we,    0);
        check("rst_l2_addr",  l2_req_addr,  0);
        check("rst_l2_wdata", l2_wdata,     0);

        // Cold load miss
        drive(1'b1, 1'b0, 32'h0000_1040);
        observe(sc, na, rf, ra);
        check("cold_stall_cycles", sc, 4);
        check("cold_refill_at",    ra, 3);
        check("cold_refills",      rf, 1);
        check("cold_nreq",         na, 1);
        check("cold_req_addr",     acc_addr[0], 32'h0000_1040);
        check("cold_req_we",       acc_we[0], 0);
        check("cold_rehit_update", update_L1, 0);

        // Store hit
        drive(1'b1, 1'b1, 32'h0000_1044);
        @(negedge clk);
        check("st_hit_stall",  stall_L1,  0);
        check("st_hit_update", update_L1, 1);
        check("st_hit_offset", offset,    6'd4);
        check("st_hit_index",  index,     6'd1);

        // Dirty eviction on same index
        drive(1'b1, 1'b0, 32'h0000_2040);
        observe(sc, na, rf, ra);
        check("dirty_stall_cycles", sc, 6);
        check("dirty_refill_at",    ra, 5);
        check("dirty_nreq",         na, 2);
        check("dirty_wb_addr",      acc_addr[0], 32'h0000_1040);
        check("dirty_wb_we",        acc_we[0], 1);
        check("dirty_wb_wdata",     acc_wdata[0], VIC);
        check("dirty_al_addr",      acc_addr[1], 32'h0000_2040);
        check("dirty_al_we",        acc_we[1], 0);

        // Backpressure: ready withheld for 5 valid cycles
        bp_need = 5;
        drive(1'b1, 1'b0, 32'h0000_3080);
        observe(sc, na, rf, ra);
        bp_need = 0;
        check("bp_stall_cycles", sc, 9);
        check("bp_refill_at",    ra, 8);
        check("bp_nreq",         na, 1);
        check("bp_req_addr",     acc_addr[0], 32'h0000_3080);

        // Combinational IDLE probes; request dropped before each edge
        for (int i = 0; i < 9; i++) begin
            @(posedge clk);
            #1;
            cpu_req_valid = tbl[i].v;
            cpu_req_we    = tbl[i].we;
            cpu_req_addr  = tbl[i].addr;
            @(negedge clk);
            check($sformatf("vec%0d_stall", i),  stall_L1,  tbl[i].stall);
            check($sformatf("vec%0d_update", i), update_L1, tbl[i].upd);
            check($sformatf("vec%0d_index", i),  index,     tbl[i].idx);
            check($sformatf("vec%0d_offset", i), offset,    tbl[i].off);
            check($sformatf("vec%0d_quiet", i),  {l2_req_valid, refill_L1}, 2'b00);
            cpu_req_valid = 1'b0;
        end

        // Reset while waiting in AL_WAIT, then a stray response
        resp_en = 1'b0;
        drive(1'b1, 1'b0, 32'h0000_4100);
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        check("alw_stall",    stall_L1,     1);
        check("alw_l2_valid", l2_req_valid, 0);
        rst = 1'b1;
        cpu_req_valid = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        resp_force = 1'b1;
        @(negedge clk);
        check("rstw_refill",   refill_L1,    0);
        check("rstw_stall",    stall_L1,     0);
        check("rstw_l2_valid", l2_req_valid, 0);
        @(posedge clk);
        #1;
        resp_force = 1'b0;
        resp_en = 1'b1;
        @(negedge clk);
        check("rstw_refill2", refill_L1, 0);
        drive(1'b1, 1'b0, 32'h0000_4100);
        observe(sc, na, rf, ra);
        check("rstw_remiss_stall", sc, 4);
        check("rstw_remiss_addr",  acc_addr[0], 32'h0000_4100);
        @(posedge clk);
        #1 cpu_req_valid = 1'b0;

`ifdef L1_D_PERF_CNT_EN
        // Counters: 2 misses, 3 plain hits, re-hits excluded
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("perf_rst_hit",  hit_cnt,  0);
        check("perf_rst_miss", miss_cnt, 0);
        drive(1'b1, 1'b0, 32'h0000_1040);
        observe(sc, na, rf, ra);
        @(posedge clk);
        repeat (3) @(posedge clk);
        #1 cpu_req_addr = 32'h0000_5040;
        observe(sc, na, rf, ra);
        @(posedge clk);
        #1 cpu_req_valid = 1'b0;
        @(negedge clk);
        check("perf_hit_cnt",  hit_cnt,  3);
        check("perf_miss_cnt", miss_cnt, 2);
`endif

        check("never_update_and_refill", both_err, 0);
        check("l2_req_held_stable",      stab_err, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
